pdp8_iobus: RTL

PDP8_IOBUS -- requirements
Module: pdp8_iobus

---
 rtl/pdp8_iobus.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/pdp8_iobus.sv
// pdp8_iobus: PDP-8 IOT bus. It arbitrates the device slots and implements device 00 (the interrupt control: ion, ion_delay, CAF).
// Latency: data, skip and select are combinational within F1. ion, io_clear and bus_conflict change on the F1 clock edge.
// Backpressure: none. The CPU major state sets the timing, and devices must answer within the F1 cycle.
module pdp8_iobus #(
  parameter  int NSLOT = 4,
  localparam int IW    = (NSLOT > 1) ? $clog2(NSLOT) : 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                iot,
  input  logic [3:0]          state,
  input  logic [11:0]         mb,
  input  logic [5:0]          io_select,
  input  logic [11:0]         io_data_in,
  input  logic [NSLOT-1:0]    dev_selected,
  input  logic [12*NSLOT-1:0] dev_data,
  input  logic [NSLOT-1:0]    dev_skip,
  input  logic [NSLOT-1:0]    dev_interrupt,
  input  logic                int_ack,
  output logic [11:0]         io_data_out,
  output logic                io_skip,
  output logic                io_selected,
  output logic                interrupt_req,
  output logic                ion,
  output logic                io_clear,
  output logic [IW-1:0]       int_dev,
  output logic                bus_conflict
);

  localparam logic [3:0] F0 = 4'd0;
  localparam logic [3:0] F1 = 4'd1;

  localparam logic [2:0] OP_SKON = 3'd0;
  localparam logic [2:0] OP_ION  = 3'd1;
  localparam logic [2:0] OP_IOF  = 3'd2;
  localparam logic [2:0] OP_SRQ  = 3'd3;
  localparam logic [2:0] OP_GTF  = 3'd4;
  localparam logic [2:0] OP_CAF  = 3'd7;

  logic        ion_q, ion_d;
  logic        ion_delay_q, ion_delay_d;
  logic        f0_cnt_q, f0_cnt_d;
  logic        io_clear_q, io_clear_d;
  logic        bus_conflict_q, bus_conflict_d;

  logic        state_vld;
  logic        f1_iot;
  logic        dev00;
  logic        multi_sel;
  logic        win_vld;
  logic        win_skp;
  logic [11:0] win_dat;
  logic [2:0]  op;
  logic        unused_mb;

  // Only the IOP bits are decoded here. The opcode and device fields arrive through iot and io_select.
  assign op        = mb[2:0];
  assign unused_mb = ^mb[11:3];

  assign state_vld = (state <= 4'd3);
  assign f1_iot    = (state == F1) && iot;
  assign dev00     = f1_iot && (io_select == 6'o00);
  // The vector has two or more bits set when clearing its lowest set bit leaves something behind.
  assign multi_sel = |(dev_selected & (dev_selected - NSLOT'(1)));

  // Lowest-index selected slot wins the bus
  always_comb begin
    win_vld = 1'b0;
    win_dat = '0;
    win_skp = 1'b0;
    for (int i = NSLOT - 1; i >= 0; i--) begin
      if (dev_selected[i]) begin
        win_vld = 1'b1;
        win_dat = dev_data[12*i +: 12];
        win_skp = dev_skip[i];
      end
    end
  end

  // Lowest-index pending interrupt; 0 when none pending
  always_comb begin
    int_dev = '0;
    for (int i = NSLOT - 1; i >= 0; i--) begin
      if (dev_interrupt[i]) int_dev = IW'(i);
    end
  end

  // IOT response: device 00 takes precedence over the slots, otherwise AC passes straight through
  always_comb begin
    io_data_out = io_data_in;
    io_skip     = 1'b0;
    io_selected = 1'b0;
    if (dev00) begin
      io_selected = 1'b1;
      case (op)
        OP_SKON: io_skip     = ion_q;
        OP_SRQ:  io_skip     = |dev_interrupt;
        OP_GTF:  io_data_out = {ion_q, 11'b0};
        default: ;
      endcase
    end else if (f1_iot && win_vld) begin
      io_selected = 1'b1;
      io_data_out = win_dat;
      io_skip     = win_skp;
    end
  end

  // Next state for the interrupt control. An illegal CPU state freezes everything except the io_clear pulse.
  always_comb begin
    ion_d          = ion_q;
    ion_delay_d    = ion_delay_q;
    f0_cnt_d       = f0_cnt_q;
    io_clear_d     = 1'b0;
    bus_conflict_d = bus_conflict_q;
    if (state_vld) begin
      io_clear_d = dev00 && (op == OP_CAF);
      if (f1_iot && (io_select != 6'o00) && multi_sel) bus_conflict_d = 1'b1;
      if (int_ack) begin
        ion_d       = 1'b0;
        ion_delay_d = 1'b0;
        f0_cnt_d    = 1'b0;
      end else if (dev00) begin
        case (op)
          OP_SKON: ion_d = 1'b0;
          OP_ION: begin
            ion_d       = 1'b1;
            ion_delay_d = 1'b1;
            f0_cnt_d    = 1'b0;
          end
          OP_IOF: begin
            ion_d       = 1'b0;
            ion_delay_d = 1'b0;
            f0_cnt_d    = 1'b0;
          end
          OP_CAF:  ion_d = 1'b0;
          default: ;
        endcase
      end else if ((state == F0) && ion_delay_q) begin
        // The first F0 after ION belongs to the next instruction. The second F0 releases the delay.
        if (f0_cnt_q) begin
          ion_delay_d = 1'b0;
          f0_cnt_d    = 1'b0;
        end else begin
          f0_cnt_d = 1'b1;
        end
      end
    end
  end

  // State flops; reset overrides int_ack, IOT effects and any delay in progress
  always_ff @(posedge clk) begin
    if (reset) begin
      ion_q          <= 1'b0;
      ion_delay_q    <= 1'b0;
      f0_cnt_q       <= 1'b0;
      io_clear_q     <= 1'b0;
      bus_conflict_q <= 1'b0;
    end else begin
      ion_q          <= ion_d;
      ion_delay_q    <= ion_delay_d;
      f0_cnt_q       <= f0_cnt_d;
      io_clear_q     <= io_clear_d;
      bus_conflict_q <= bus_conflict_d;
    end
  end

  assign ion           = ion_q;
  assign io_clear      = io_clear_q;
  assign bus_conflict  = bus_conflict_q;
  assign interrupt_req = ion_q & ~ion_delay_q & (|dev_interrupt);

endmodule
